klein_stream_ctrl: RTL
======================

Name: klein_stream_ctrl

Overview:
Byte-serial front/back end for the serial KLEIN-80 core (klein_80). It accepts one 64-bit block plus an 80-bit key through a valid/ready handshake and issues the core's one-cycle start pulse. It streams key and data bytes into the core, then deserialises the 8 ciphertext bytes the core emits after ready. The assembled 64-bit result is presented through a valid/ready handshake; upstream is the system bus, downstream is the result consumer.

Parameters:
BLK_W, 64, block width in bits; fixed, 8 bytes.
KEY_W, 80, key width in bits; fixed, 10 bytes.
MAX_WAIT, 1024, BUSY cycles allowed without core_ready before timeout.
CNT_W, 11, width of wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
ck  in  1  rising-edge clock, single domain
rst  in  1  synchronous, active-high reset
in_valid  in  1  block+key offered
in_ready  out  1  controller can accept (IDLE only)
in_data  in  [0:63]  plaintext, bit 0 = MSB, byte 0 = bits [0:7]
in_key  in  [0:79]  key, byte 0 = bits [0:7]
core_start  out  1  one-cycle start pulse to core
core_inp  out  [0:7]  data byte to core
core_key  out  [0:7]  key byte to core
core_ready  in  1  core pulse, coincident with ciphertext byte 0
core_out  in  [0:7]  ciphertext byte from core
res_valid  out  1  res_data holds a complete ciphertext
res_ready  in  1  consumer accepts result
res_data  out  [0:63]  ciphertext, byte 0 = bits [0:7]
err_timeout  out  1  one-cycle pulse on core timeout

Behaviour:
- All outputs are registered. Reset values: in_ready=0, core_start=0, core_inp=0x00, core_key=0x00, res_valid=0, res_data=0, err_timeout=0. The first cycle after reset is IDLE with in_ready=1.
- States: IDLE, LOAD, BUSY, COLLECT, DONE. There is a 4-bit byte counter bc and a CNT_W-bit wait counter wc.
- IDLE: in_ready=1. On in_valid&in_ready at cycle T:
  - latch in_data and in_key into shift registers;
  - set bc=0 and go to LOAD.
- LOAD: core_start=1 only at bc=0, at cycle T+1.
  - At bc=k: core_key = key byte k.
  - core_inp = data byte k for k<8; core_inp = 0x00 for k=8,9.
  - After bc=9 (cycle T+10), drive core_inp/core_key to 0x00, clear wc, go to BUSY.
- BUSY: wc increments each cycle.
  - core_ready=1 captures core_out as byte 0, sets bc=1 and goes to COLLECT.
  - If wc reaches MAX_WAIT-1 with no core_ready: err_timeout=1 for one cycle, then go to IDLE. res_data is unchanged.
- COLLECT: capture core_out as byte bc each cycle. Byte 7 is captured at R+7, where R is the core_ready cycle. Then go to DONE; res_valid=1 at R+8.
  - core_ready is ignored during COLLECT.
- DONE: res_valid and res_data are held stable until res_valid&res_ready.
  - On that handshake go to IDLE; res_valid=0 and in_ready=1 on the next cycle.
  - No input is accepted in the same cycle as the result handshake.
- core_ready in IDLE, LOAD or DONE is ignored with no state change.
- in_valid outside IDLE is ignored (in_ready=0); upstream must hold its data.
- rst asserted in any state returns all outputs to reset values on the next edge. Partially collected bytes are discarded and no err_timeout is generated.
- Minimum accept-to-result latency is 10 (LOAD) + core latency + 8 cycles.

Decomposition:
- Shared package klein_pkg holds:
  - BLK_BYTES=8, KEY_BYTES=10;
  - state encoding (IDLE=0, LOAD=1, BUSY=2, COLLECT=3, DONE=4);
  - a byte-select function for [0:N] vectors.
- One natural sub-module, klein_byte_deser: an 8-byte shift-in register with capture enable and a done flag. It is used for the COLLECT path; the LOAD path stays in the top FSM.

Test Plan:
- Basic flow: in_data=0x0000000000000000, in_key=0xFFFFFFFFFFFFFFFFFFFF; bench core model asserts core_ready 20 cycles after start and outputs bytes 0x01..0x08.
  - Required: core_start exactly once, at T+1.
  - Required: core_key=0xFF for 10 cycles, core_inp=0x00 for 10 cycles.
  - Required: res_data=0x0102030405060708, with res_valid at R+8.
- Byte ordering: in_data=0x1234567890ABCDEF, in_key=0x00112233445566778899.
  - Required: core_inp sequence 12,34,56,78,90,AB,CD,EF,00,00.
  - Required: core_key sequence 00,11,...,99.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid.
  - Required: res_data stable and in_ready=0 throughout.
  - Required: in_valid offered meanwhile is not accepted; in_ready=1 the cycle after res_ready.
- Timeout: MAX_WAIT=16 and the model never asserts core_ready.
  - Required: err_timeout pulses once, 16 cycles into BUSY.
  - Required: return to IDLE with res_valid=0.
- Reset mid-operation: assert rst at COLLECT byte 3.
  - Required: next cycle all outputs are at reset values; then in_ready=1.
  - Required: a fresh transaction completes correctly.
- Spurious core_ready: pulse core_ready during LOAD.
  - Required: no capture and no state change; normal result follows.

Source files
------------

// File: rtl/klein_pkg.sv
// Shared definitions for the KLEIN-80 byte-serial stream controller:
// byte counts, FSM state encoding and a byte picker for MSB-first vectors.
package klein_pkg;

  localparam int BLK_BYTES = 8;
  localparam int KEY_BYTES = 10;
  // Widest vector the byte picker handles (the 80-bit key).
  localparam int SEL_W     = KEY_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    BUSY    = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Byte k of an ascending [0:N] vector; byte 0 is bits [0:7].
  function automatic logic [7:0] sel_byte(input logic [0:SEL_W-1] v, input logic [3:0] k);
    logic [6:0] base;
    base = {k, 3'b000};
    return v[base +: 8];
  endfunction

endpackage

// File: rtl/klein_byte_deser.sv
// 8-byte shift-in register. Bytes arrive first-to-last on din while cap_en
// is high; the assembled word is published only when the eighth byte lands,
// so word never shows a partially collected block.
module klein_byte_deser
  import klein_pkg::*;
(
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   cap_en,
  input  logic [7:0]             din,
  output logic [0:BLK_BYTES*8-1] word,
  output logic                   done
);

  localparam int SH_W = (BLK_BYTES - 1) * 8;

  logic [SH_W-1:0] sh_reg;
  logic [2:0]      cnt_reg;

  // High in the cycle the final byte of a block is being captured.
  assign done = cap_en && (cnt_reg == 3'(BLK_BYTES - 1));

  // Shift bytes in; the counter wraps to 0 after a full block.
  always_ff @(posedge ck) begin
    if (rst) begin
      sh_reg  <= '0;
      cnt_reg <= '0;
      word    <= '0;
    end else if (cap_en) begin
      sh_reg  <= {sh_reg[SH_W-9:0], din};
      cnt_reg <= cnt_reg + 3'd1;
      if (done) begin
        word <= {sh_reg, din};
      end
    end
  end

endmodule

// File: rtl/klein_stream_ctrl.sv
// Byte-serial front/back end for the KLEIN-80 core. Accepts a block+key,
// pulses core_start, streams 10 key bytes (and 8 data bytes, then zeros) into
// the core, waits for core_ready with a timeout, then deserialises the 8
// ciphertext bytes and holds them until the consumer takes them.
module klein_stream_ctrl
  import klein_pkg::*;
#(
  parameter int BLK_W    = 64,
  parameter int KEY_W    = 80,
  parameter int MAX_WAIT = 1024,
  parameter int CNT_W    = 11
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:BLK_W-1] in_data,
  input  logic [0:KEY_W-1] in_key,
  output logic             core_start,
  output logic [0:7]       core_inp,
  output logic [0:7]       core_key,
  input  logic             core_ready,
  input  logic [0:7]       core_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [0:BLK_W-1] res_data,
  output logic             err_timeout
);

  // Data is zero-padded to key length so bytes 8 and 9 come out as 0x00.
  localparam int PAD_W = KEY_W - BLK_W;

  state_t           state_reg, state_next;
  logic [3:0]       bc_reg, bc_next;
  logic [CNT_W-1:0] wc_reg, wc_next;
  logic [0:BLK_W-1] data_reg, data_next;
  logic [0:KEY_W-1] key_reg, key_next;

  logic       in_ready_next;
  logic       core_start_next;
  logic [7:0] core_inp_next;
  logic [7:0] core_key_next;
  logic       res_valid_next;
  logic       err_timeout_next;

  logic cap_en;
  logic col_done;

  klein_byte_deser u_deser (
    .ck     (ck),
    .rst    (rst),
    .cap_en (cap_en),
    .din    (core_out),
    .word   (res_data),
    .done   (col_done)
  );

  // Next-state and next-output logic; outputs are registered one cycle later.
  always_comb begin
    state_next       = state_reg;
    bc_next          = bc_reg;
    wc_next          = wc_reg;
    data_next        = data_reg;
    key_next         = key_reg;
    in_ready_next    = 1'b0;
    core_start_next  = 1'b0;
    core_inp_next    = 8'h00;
    core_key_next    = 8'h00;
    res_valid_next   = 1'b0;
    err_timeout_next = 1'b0;
    cap_en           = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready_next = 1'b1;
        if (in_valid && in_ready) begin
          data_next       = in_data;
          key_next        = in_key;
          bc_next         = 4'd0;
          state_next      = LOAD;
          in_ready_next   = 1'b0;
          core_start_next = 1'b1;
          core_inp_next   = sel_byte({in_data, {PAD_W{1'b0}}}, 4'd0);
          core_key_next   = sel_byte(in_key, 4'd0);
        end
      end

      LOAD: begin
        if (bc_reg == 4'(KEY_BYTES - 1)) begin
          wc_next    = '0;
          state_next = BUSY;
        end else begin
          bc_next       = bc_reg + 4'd1;
          core_inp_next = sel_byte({data_reg, {PAD_W{1'b0}}}, bc_reg + 4'd1);
          core_key_next = sel_byte(key_reg, bc_reg + 4'd1);
        end
      end

      BUSY: begin
        wc_next = wc_reg + CNT_W'(1);
        if (core_ready) begin
          // core_ready coincides with ciphertext byte 0.
          cap_en     = 1'b1;
          state_next = COLLECT;
        end else if (wc_reg == CNT_W'(MAX_WAIT - 1)) begin
          err_timeout_next = 1'b1;
          in_ready_next    = 1'b1;
          state_next       = IDLE;
        end
      end

      COLLECT: begin
        cap_en = 1'b1;
        if (col_done) begin
          res_valid_next = 1'b1;
          state_next     = DONE;
        end
      end

      DONE: begin
        res_valid_next = 1'b1;
        if (res_valid && res_ready) begin
          res_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State, counters, latched operands and all registered outputs.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg   <= IDLE;
      bc_reg      <= '0;
      wc_reg      <= '0;
      data_reg    <= '0;
      key_reg     <= '0;
      in_ready    <= 1'b0;
      core_start  <= 1'b0;
      core_inp    <= '0;
      core_key    <= '0;
      res_valid   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bc_reg      <= bc_next;
      wc_reg      <= wc_next;
      data_reg    <= data_next;
      key_reg     <= key_next;
      in_ready    <= in_ready_next;
      core_start  <= core_start_next;
      core_inp    <= core_inp_next;
      core_key    <= core_key_next;
      res_valid   <= res_valid_next;
      err_timeout <= err_timeout_next;
    end
  end

endmodule
